// File: rtl/dmem_port_arbiter.sv
// Arbitrates the single-port data memory between the processor load/store path
// and the plotter engine master. The processor wins unless the engine has starved.
module dmem_port_arbiter #(
    parameter int ADDR_W       = 12,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 4,
    parameter int CNT_W        = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              p_req,
    input  logic [ADDR_W-1:0] p_addr,
    input  logic [DATA_W-1:0] p_wdata,
    input  logic              p_wren,
    output logic              p_stall,
    output logic [DATA_W-1:0] p_rdata,
    input  logic              e_req,
    input  logic [ADDR_W-1:0] e_addr,
    input  logic [DATA_W-1:0] e_wdata,
    input  logic              e_wren,
    output logic              e_gnt,
    output logic              e_rvalid,
    output logic [DATA_W-1:0] e_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_wren,
    input  logic [DATA_W-1:0] mem_q
);

    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

    logic [CNT_W-1:0]  starve_cnt;
    logic              eng_win;
    logic              vld_p1;
    logic [DATA_W-1:0] rdata_p1;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v >= LIMIT) ? LIMIT : v + CNT_W'(1);
    endfunction

    always_comb begin
        eng_win   = e_req & (~p_req | (starve_cnt == LIMIT));
        e_gnt     = eng_win & ~reset;
        p_stall   = eng_win & p_req & ~reset;
        p_rdata   = mem_q;
        mem_addr  = p_addr;
        mem_wdata = p_wdata;
        mem_wren  = p_wren & p_req & ~reset;
        if (eng_win) begin
            mem_addr  = e_addr;
            mem_wdata = e_wdata;
            mem_wren  = e_wren & ~reset;
        end
    end

    // stage p1: starvation count and registered engine read return
    always_ff @(posedge clock) begin
        if (reset) begin
            starve_cnt <= '0;
            vld_p1     <= 1'b0;
            rdata_p1   <= '0;
        end else begin
            if (!e_req || e_gnt) starve_cnt <= '0;
            else                 starve_cnt <= sat_inc(starve_cnt);
            vld_p1 <= e_gnt & ~e_wren;
            if (e_gnt && !e_wren) rdata_p1 <= mem_q;
        end
    end

    assign e_rvalid = vld_p1;
    assign e_rdata  = rdata_p1;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Scoreboard bench for dmem_port_arbiter with a falling-edge dmem model and
// directed vectors; the monitor pops per-cycle and read-return expectations.
module tb_dmem_port_arbiter;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        p_req = 1'b0, p_wren = 1'b0, e_req = 1'b0, e_wren = 1'b0;
    logic [11:0] p_addr = '0, e_addr = '0;
    logic [31:0] p_wdata = '0, e_wdata = '0;
    logic        p_stall, e_gnt, e_rvalid, mem_wren;
    logic [31:0] p_rdata, e_rdata, mem_wdata;
    logic [11:0] mem_addr;
    logic [31:0] mem_q = '0;
    logic [31:0] mem [0:4095];

    typedef struct {
        logic [3:0]  ctl;
        logic        cp;
        logic [31:0] xp;
        logic        ce;
        logic [31:0] xe;
    } exp_t;

    exp_t        ctl_q[$];
    logic [31:0] rd_q[$];
    int          passed = 0;
    int          total  = 0;
    int          cyc_n  = 0;
    bit          done   = 0;

    dmem_port_arbiter dut (
        .clock(clock), .reset(reset),
        .p_req(p_req), .p_addr(p_addr), .p_wdata(p_wdata), .p_wren(p_wren),
        .p_stall(p_stall), .p_rdata(p_rdata),
        .e_req(e_req), .e_addr(e_addr), .e_wdata(e_wdata), .e_wren(e_wren),
        .e_gnt(e_gnt), .e_rvalid(e_rvalid), .e_rdata(e_rdata),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wren(mem_wren),
        .mem_q(mem_q)
    );

    always #5 clock = ~clock;

    always @(negedge clock) begin
        if (mem_wren) mem[mem_addr] <= mem_wdata;
        mem_q <= mem[mem_addr];
    end

    function automatic void chk(string name, logic [31:0] act, logic [31:0] req);
        total++;
        if (act === req) passed++;
        else $display("FAIL %s cycle %0d: got %h required %h", name, cyc_n, act, req);
    endfunction

    task automatic drive(input logic rst, input logic pr, input logic [11:0] pa,
                         input logic [31:0] pd, input logic pw, input logic er,
                         input logic [11:0] ea, input logic [31:0] ed, input logic ew);
        @(posedge clock);
        #1;
        cyc_n++;
        reset = rst; p_req = pr; p_addr = pa; p_wdata = pd; p_wren = pw;
        e_req = er; e_addr = ea; e_wdata = ed; e_wren = ew;
    endtask

    // ctl bits: {e_gnt, p_stall, mem_wren, e_rvalid}
    task automatic expect_cyc(input logic [3:0] ctl, input logic cp, input logic [31:0] xp,
                              input logic ce, input logic [31:0] xe);
        exp_t r;
        r.ctl = ctl; r.cp = cp; r.xp = xp; r.ce = ce; r.xe = xe;
        ctl_q.push_back(r);
    endtask

    task automatic contend_rd(input logic [11:0] ea);
        drive(0, 1, 12'h010, 32'h0, 0, 1, ea, 32'h0, 0);
    endtask

    task automatic idle();
        drive(0, 0, 12'h010, 32'h0, 0, 0, 12'h0, 32'h0, 0);
    endtask

    // monitor
    initial begin
        exp_t r;
        forever begin
            @(posedge clock);
            #8;
            if (ctl_q.size() > 0) begin
                r = ctl_q.pop_front();
                chk("e_gnt",    {31'b0, e_gnt},    {31'b0, r.ctl[3]});
                chk("p_stall",  {31'b0, p_stall},  {31'b0, r.ctl[2]});
                chk("mem_wren", {31'b0, mem_wren}, {31'b0, r.ctl[1]});
                chk("e_rvalid", {31'b0, e_rvalid}, {31'b0, r.ctl[0]});
                if (r.cp) chk("p_rdata", p_rdata, r.xp);
                if (r.ce) chk("e_rdata_hold", e_rdata, r.xe);
            end
            if (e_rvalid === 1'b1) begin
                if (rd_q.size() == 0) chk("unexpected_rvalid", 32'd1, 32'd0);
                else chk("e_rdata", e_rdata, rd_q.pop_front());
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int i = 0; i < 4096; i++) mem[i] = 32'h0;
        mem[12'h020] = 32'h12345678;
        mem[12'h040] = 32'hCAFEF00D;

        // reset: outputs quiet even with requests and a would-be engine win
        drive(1, 1, 12'h010, 32'hBAD0BAD0, 1, 0, 12'h0, 32'h0, 0);
        expect_cyc(4'b0000, 0, 0, 1, 32'h0);
        drive(1, 0, 12'h010, 32'h0, 0, 1, 12'h020, 32'h0, 0);
        expect_cyc(4'b0000, 0, 0, 1, 32'h0);

        // processor only: store then load
        drive(0, 1, 12'h010, 32'hDEADBEEF, 1, 0, 12'h0, 32'h0, 0);
        expect_cyc(4'b0010, 0, 0, 1, 32'h0);
        drive(0, 1, 12'h010, 32'h0, 0, 0, 12'h0, 32'h0, 0);
        expect_cyc(4'b0000, 1, 32'hDEADBEEF, 0, 0);

        // engine only read
        drive(0, 0, 12'h010, 32'h0, 0, 1, 12'h020, 32'h0, 0);
        expect_cyc(4'b1000, 0, 0, 0, 0);
        rd_q.push_back(32'h12345678);
        idle();
        expect_cyc(4'b0001, 0, 0, 0, 0);
        idle();
        expect_cyc(4'b0000, 0, 0, 1, 32'h12345678);

        // contention: forced grant in cycles 4 and 9
        for (int i = 0; i < 10; i++) begin
            contend_rd(12'h040);
            if (i == 4 || i == 9) begin
                expect_cyc(4'b1100, 0, 0, 0, 0);
                rd_q.push_back(32'hCAFEF00D);
            end else begin
                expect_cyc({3'b000, i == 5}, 1, 32'hDEADBEEF, 0, 0);
            end
        end

        // engine write under contention, then processor reads it back
        for (int i = 0; i < 5; i++) begin
            drive(0, 1, 12'h010, 32'h0, 0, 1, 12'h030, 32'hA5A5A5A5, 1);
            if (i == 4) expect_cyc(4'b1110, 0, 0, 0, 0);
            else        expect_cyc({3'b000, i == 0}, 1, 32'hDEADBEEF, 0, 0);
        end
        drive(0, 1, 12'h030, 32'h0, 0, 0, 12'h0, 32'h0, 0);
        expect_cyc(4'b0000, 1, 32'hA5A5A5A5, 0, 0);

        // withdrawal clears the count
        for (int i = 0; i < 3; i++) begin
            contend_rd(12'h040);
            expect_cyc(4'b0000, 1, 32'hDEADBEEF, 0, 0);
        end
        drive(0, 1, 12'h010, 32'h0, 0, 0, 12'h040, 32'h0, 0);
        expect_cyc(4'b0000, 1, 32'hDEADBEEF, 0, 0);
        for (int i = 0; i < 5; i++) begin
            contend_rd(12'h040);
            if (i == 4) begin
                expect_cyc(4'b1100, 0, 0, 0, 0);
                rd_q.push_back(32'hCAFEF00D);
            end else begin
                expect_cyc(4'b0000, 1, 32'hDEADBEEF, 0, 0);
            end
        end

        // reset lands on a forced read grant
        for (int i = 0; i < 4; i++) begin
            contend_rd(12'h020);
            expect_cyc({3'b000, i == 0}, 0, 0, 0, 0);
        end
        drive(1, 1, 12'h010, 32'h0, 0, 1, 12'h020, 32'h0, 0);
        expect_cyc(4'b0000, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) begin
            contend_rd(12'h020);
            if (i == 4) begin
                expect_cyc(4'b1100, 0, 0, 0, 0);
                rd_q.push_back(32'h12345678);
            end else begin
                expect_cyc(4'b0000, 0, 0, i == 0, 32'h0);
            end
        end
        idle();
        expect_cyc(4'b0001, 0, 0, 0, 0);
        idle();
        expect_cyc(4'b0000, 0, 0, 1, 32'h12345678);

        // back-to-back engine grants with the processor idle
        drive(0, 0, 12'h010, 32'h0, 0, 1, 12'h020, 32'h0, 0);
        expect_cyc(4'b1000, 0, 0, 0, 0);
        rd_q.push_back(32'h12345678);
        drive(0, 0, 12'h010, 32'h0, 0, 1, 12'h040, 32'h0, 0);
        expect_cyc(4'b1001, 0, 0, 0, 0);
        rd_q.push_back(32'hCAFEF00D);
        idle();
        expect_cyc(4'b0001, 0, 0, 0, 0);
        idle();
        expect_cyc(4'b0000, 0, 0, 1, 32'hCAFEF00D);

        @(posedge clock);
        @(posedge clock);
        #9;
        chk("ctl_q_left", ctl_q.size(), 32'd0);
        chk("rd_q_left", rd_q.size(), 32'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/dmem_port_arbiter.md
Name: dmem_port_arbiter

Overview:
- Shares the single-port data memory between two requesters: the processor's load/store path and the plotter command/engine master (E).
- The processor has priority and normally never waits.
- A starvation counter forces an engine slot after STARVE_LIMIT consecutive denials; in that cycle the processor is stalled for one cycle.
- Sits between the processor/engine and the dmem instance, which is clocked on the inverted clock.

Parameters:
- ADDR_W, 12, dmem address width.
- DATA_W, 32, dmem data width.
- STARVE_LIMIT, 4, consecutive denied engine cycles before a forced grant; legal range 1..255.
- CNT_W, 8, starvation counter width; must satisfy 2^CNT_W > STARVE_LIMIT.

Ports:
- clock  in  1  master clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- p_req  in  1  processor load/store active this cycle.
- p_addr  in  ADDR_W  processor address.
- p_wdata  in  DATA_W  processor store data.
- p_wren  in  1  processor store enable; meaningful only with p_req.
- p_stall  out  1  processor must hold its instruction this cycle.
- p_rdata  out  DATA_W  load data to processor.
- e_req  in  1  engine request; held until e_gnt.
- e_addr  in  ADDR_W  engine address.
- e_wdata  in  DATA_W  engine write data.
- e_wren  in  1  engine write (1) or read (0).
- e_gnt  out  1  engine request accepted this cycle.
- e_rvalid  out  1  registered pulse: e_rdata holds read result.
- e_rdata  out  DATA_W  registered engine read data.
- mem_addr  out  ADDR_W  to dmem address.
- mem_wdata  out  DATA_W  to dmem data.
- mem_wren  out  1  to dmem wren.
- mem_q  in  DATA_W  from dmem q.

Behaviour:
- Owner is decided combinationally each cycle:
  - eng_win = e_req & (~p_req | (starve_cnt == STARVE_LIMIT)); otherwise the processor is owner.
- e_gnt = eng_win & ~reset.
- p_stall = eng_win & p_req & ~reset.
- Memory mux:
  - eng_win=1: mem_addr=e_addr, mem_wdata=e_wdata, mem_wren=e_wren.
  - Else: mem_addr=p_addr, mem_wdata=p_wdata, mem_wren=p_wren & p_req.
  - During reset mem_wren=0, whichever owner.
- No requester active: mem_addr=p_addr, mem_wren=0.
- p_rdata = mem_q (combinational passthrough). The processor ignores it while p_stall=1.
- Starvation counter, on the rising edge:
  - reset: cnt=0.
  - Else if e_req=0 or e_gnt=1: cnt=0.
  - Else (denied): cnt=cnt+1, saturating at STARVE_LIMIT.
- After a forced grant the counter is 0, so the processor wins the next STARVE_LIMIT contended cycles. This bounds processor stall to 1 cycle in every STARVE_LIMIT+1.
- Engine read return:
  - On the rising edge, if e_gnt & ~e_wren: e_rvalid<=1 and e_rdata<=mem_q. dmem updates on the falling edge, so mem_q is valid by then.
  - Else e_rvalid<=0; e_rdata holds its value.
- Engine write: completes in the e_gnt cycle; no e_rvalid.
- Back-to-back engine grants are allowed every cycle while the processor is idle. Throughput is 1 access/cycle, read latency 1 cycle from e_gnt.
- Handshake rules:
  - The engine keeps e_req, e_addr, e_wdata and e_wren stable until it sees e_gnt.
  - Dropping e_req before e_gnt withdraws the request and clears the counter.
- Reset values: cnt=0, e_rvalid=0, e_rdata=0. e_gnt, p_stall and mem_wren are 0 while reset=1.
- Reset mid-operation: a grant in the reset cycle is suppressed. No e_rvalid follows it and no write reaches dmem.

Test Plan:
- Processor only (p_req=1, sw then lw at addr 0x010, data 0xDEADBEEF): p_stall stays 0; load returns 0xDEADBEEF; e_gnt never rises.
- Engine only (p_req=0, read at 0x020 preloaded 0x12345678): e_gnt=1 the same cycle; e_rvalid=1 with e_rdata=0x12345678 on the next cycle, then 0.
- Contention (STARVE_LIMIT=4, p_req and e_req held high): e_gnt low for cycles 0-3 and high in cycle 4 with p_stall=1 in cycle 4; next e_gnt in cycle 9; the pattern repeats.
- Engine write under contention (e_wren=1, addr 0x030, data 0xA5A5A5A5): mem_wren=1 only in the forced grant cycle; a subsequent processor lw at 0x030 returns 0xA5A5A5A5; no e_rvalid.
- Withdrawal: e_req high for 3 denied cycles, low for 1, then high again. The counter restarts from 0, so the grant comes 4 denied cycles after re-assertion, not 1.
- Reset mid-read: assert reset in the cycle of an engine read grant. Required: e_gnt=0, mem_wren=0, e_rvalid=0 the next cycle, counter=0.
